// File: rtl/puf_ro_counter.sv
// Ring-oscillator PUF measurement block: enables two ROs, counts their synchronized
// rising edges over a fixed window and reports which oscillator was faster.

module puf_ro_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_ro,
    output logic o_rise
);

    logic sync_1;
    logic sync_2;
    logic hist;

    // Two synchronizer flops then a history flop; the edge is taken between the last two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            hist   <= 1'b0;
        end else begin
            sync_1 <= i_ro;
            sync_2 <= sync_1;
            hist   <= sync_2;
        end
    end

    assign o_rise = sync_2 & ~hist;

endmodule

module puf_ro_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_cnt <= '0;
        end else if (i_clear) begin
            o_cnt <= '0;
        end else if (i_inc && (o_cnt != CNT_MAX)) begin
            o_cnt <= o_cnt + CNT_W'(1);
        end
    end

endmodule

module puf_ro_counter #(
    parameter int CNT_W         = 16,
    parameter int WIN_CYCLES    = 1024,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    output logic             o_en_a,
    output logic             o_en_b,
    input  logic             i_ro_a,
    input  logic             i_ro_b,
    output logic             o_busy,
    output logic             o_valid,
    output logic             o_resp,
    output logic             o_tie,
    output logic [CNT_W-1:0] o_cnt_a,
    output logic [CNT_W-1:0] o_cnt_b
);

    localparam int CYC_W = 21;
    localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
    localparam logic [CYC_W-1:0] WIN_LAST    = CYC_W'(WIN_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CYC_W-1:0] cyc_cnt;
    logic             clear;
    logic             count_en;
    logic             capture;
    logic             rise_a;
    logic             rise_b;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    puf_ro_sync_edge u_edge_a (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_ro    (i_ro_a),
        .o_rise  (rise_a)
    );

    puf_ro_sync_edge u_edge_b (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_ro    (i_ro_b),
        .o_rise  (rise_b)
    );

    puf_ro_sat_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (clear),
        .i_inc   (count_en & rise_a),
        .o_cnt   (cnt_a)
    );

    puf_ro_sat_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (clear),
        .i_inc   (count_en & rise_b),
        .o_cnt   (cnt_b)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The final MEASURE cycle is the transition cycle, so its edges are not counted.
    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        count_en  = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nxt = SETTLE;
                    clear     = 1'b1;
                end
            end
            SETTLE: begin
                if (cyc_cnt == SETTLE_LAST) begin
                    state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                if (cyc_cnt == WIN_LAST) begin
                    state_nxt = DONE;
                    capture   = 1'b1;
                end else begin
                    count_en  = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cyc_cnt <= '0;
        end else if (state_nxt != state) begin
            cyc_cnt <= '0;
        end else if ((state == SETTLE) || (state == MEASURE)) begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
        end
    end

    // Results are loaded on entry to DONE and held until the next measurement completes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_cnt_a <= '0;
            o_cnt_b <= '0;
            o_resp  <= 1'b0;
            o_tie   <= 1'b0;
        end else if (capture) begin
            o_cnt_a <= cnt_a;
            o_cnt_b <= cnt_b;
            o_resp  <= (cnt_a > cnt_b);
            o_tie   <= (cnt_a == cnt_b);
        end
    end

    assign o_en_a  = (state == SETTLE) || (state == MEASURE);
    assign o_en_b  = (state == SETTLE) || (state == MEASURE);
    assign o_busy  = (state != IDLE);
    assign o_valid = (state == DONE);

endmodule

// File: tb/tb_puf_ro_counter.sv
// Directed bench for puf_ro_counter: modelled ring oscillators, scoreboard of expected
// results checked whenever the DUT pulses o_valid.
`timescale 1ns/1ps

module tb_puf_ro_counter;

    localparam int WIN = 100;
    localparam int SET = 8;
    localparam int LAT = SET + WIN + 1;

    typedef struct {
        int   start_cyc;
        int   a_lo;
        int   a_hi;
        int   b_lo;
        int   b_hi;
        logic resp;
        logic tie;
        bit   chk_eq;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        ro_a;
    logic        ro_b;
    logic        en_a;
    logic        en_b;
    logic        busy;
    logic        valid;
    logic        resp;
    logic        tie;
    logic [15:0] cnt_a;
    logic [15:0] cnt_b;

    logic        start_s;
    logic        ro_s_a;
    logic        ro_s_b;
    logic        en_s_a;
    logic        en_s_b;
    logic        busy_s;
    logic        valid_s;
    logic        resp_s;
    logic        tie_s;
    logic [3:0]  cnt_s_a;
    logic [3:0]  cnt_s_b;

    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   n_valid = 0;
    int   half_a  = 20;
    int   half_b  = 25;
    exp_t sb[$];
    exp_t last_exp;

    puf_ro_counter #(.CNT_W(16), .WIN_CYCLES(WIN), .SETTLE_CYCLES(SET)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .o_en_a  (en_a),
        .o_en_b  (en_b),
        .i_ro_a  (ro_a),
        .i_ro_b  (ro_b),
        .o_busy  (busy),
        .o_valid (valid),
        .o_resp  (resp),
        .o_tie   (tie),
        .o_cnt_a (cnt_a),
        .o_cnt_b (cnt_b)
    );

    puf_ro_counter #(.CNT_W(4), .WIN_CYCLES(WIN), .SETTLE_CYCLES(SET)) u_dut_sat (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start_s),
        .o_en_a  (en_s_a),
        .o_en_b  (en_s_b),
        .i_ro_a  (ro_s_a),
        .i_ro_b  (ro_s_b),
        .o_busy  (busy_s),
        .o_valid (valid_s),
        .o_resp  (resp_s),
        .o_tie   (tie_s),
        .o_cnt_a (cnt_s_a),
        .o_cnt_b (cnt_s_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Oscillators start 3 ns after enable so their toggles never coincide with clock edges.
    always begin
        ro_a = 1'b0;
        wait (en_a === 1'b1);
        #3;
        while (en_a === 1'b1) begin
            #(half_a);
            if (en_a === 1'b1) ro_a = ~ro_a;
        end
    end

    always begin
        ro_b = 1'b0;
        wait (en_b === 1'b1);
        #3;
        while (en_b === 1'b1) begin
            #(half_b);
            if (en_b === 1'b1) ro_b = ~ro_b;
        end
    end

    always begin
        ro_s_a = 1'b0;
        wait (en_s_a === 1'b1);
        #3;
        while (en_s_a === 1'b1) begin
            #15;
            if (en_s_a === 1'b1) ro_s_a = ~ro_s_a;
        end
    end

    initial ro_s_b = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic checkRange(input string tag, input logic [31:0] obs, input int lo, input int hi);
        logic in_rng;
        in_rng = (obs >= lo) && (obs <= hi);
        checks++;
        assert (in_rng === 1'b1) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge: queue the expected result, then request one measurement.
    task automatic applyStimulus(input int ha, input int hb, input int alo, input int ahi,
                                 input int blo, input int bhi, input logic r, input logic t,
                                 input bit eq);
        exp_t e;
        half_a      = ha;
        half_b      = hb;
        e.start_cyc = cyc;
        e.a_lo      = alo;
        e.a_hi      = ahi;
        e.b_lo      = blo;
        e.b_hi      = bhi;
        e.resp      = r;
        e.tie       = t;
        e.chk_eq    = eq;
        sb.push_back(e);
        $display("[TB] start: ro_a half %0d ns, ro_b half %0d ns", ha, hb);
        pulseStart();
    endtask

    task automatic waitResult(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL result_timeout observed=pending expected=valid within %0d cycles", budget);
            sb.delete();
        end
    endtask

    task automatic checkHeld(input string tag);
        repeat (3) @(negedge clk);
        checkOutput({tag, "_valid_pulse"}, valid, 1'b0);
        checkOutput({tag, "_resp_held"}, resp, last_exp.resp);
        checkRange({tag, "_cnt_a_held"}, cnt_a, last_exp.a_lo, last_exp.a_hi);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid === 1'b1) begin
            exp_t e;
            n_valid++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("[TB] FAIL unexpected_valid observed=1 expected=0");
            end else begin
                e        = sb.pop_front();
                last_exp = e;
                checkOutput("latency", cyc - e.start_cyc, LAT);
                checkRange("cnt_a", cnt_a, e.a_lo, e.a_hi);
                checkRange("cnt_b", cnt_b, e.b_lo, e.b_hi);
                checkOutput("resp", resp, e.resp);
                checkOutput("tie", tie, e.tie);
                if (e.chk_eq) checkOutput("tie_diff", cnt_a - cnt_b, 0);
            end
        end
    end

    initial begin
        int n;
        int v0;
        int s_start;
        rst_n   = 1'b0;
        start   = 1'b0;
        start_s = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset_ctrl", {en_a, en_b, busy, valid, resp, tie}, 6'b0);
        checkOutput("reset_cnt_a", cnt_a, 0);
        checkOutput("reset_cnt_b", cnt_b, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic measurement: A faster than B.
        applyStimulus(20, 25, 24, 26, 19, 21, 1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("busy_en_settle", {busy, en_a, en_b}, 3'b111);
        waitResult(200);
        checkHeld("run1");

        // Swapped periods; previous result must hold while the new one is measured.
        applyStimulus(25, 20, 19, 21, 24, 26, 1'b0, 1'b0, 1'b0);
        repeat (50) @(negedge clk);
        checkOutput("run1_resp_during_run2", resp, 1'b1);
        checkRange("run1_cnt_a_during_run2", cnt_a, 24, 26);
        waitResult(200);
        checkHeld("run2");

        // Equal in-phase oscillators.
        applyStimulus(20, 20, 24, 26, 24, 26, 1'b0, 1'b1, 1'b1);
        waitResult(200);
        checkHeld("tie");

        // Start pulses in SETTLE, MEASURE and DONE must all be ignored.
        v0 = n_valid;
        applyStimulus(20, 25, 24, 26, 19, 21, 1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        pulseStart();
        repeat (30) @(negedge clk);
        pulseStart();
        n = 0;
        while (valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("busy_run_valid_seen", valid, 1'b1);
        pulseStart();
        checkOutput("start_in_done_ignored", busy, 1'b0);
        waitResult(10);
        repeat (120) @(negedge clk);
        checkOutput("busy_run_one_valid", n_valid - v0, 1);
        checkOutput("busy_run_idle", busy, 1'b0);

        // Reset at cycle 50 of MEASURE aborts the run and drops the enables at once.
        v0 = n_valid;
        half_a = 20;
        half_b = 25;
        pulseStart();
        repeat (SET + 49) @(negedge clk);
        checkOutput("pre_reset_busy_en", {busy, en_a, en_b}, 3'b111);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_ctrl", {en_a, en_b, busy, valid}, 4'b0);
        repeat (5) @(negedge clk);
        checkOutput("reset_no_valid", n_valid - v0, 0);
        rst_n = 1'b1;
        applyStimulus(20, 25, 24, 26, 19, 21, 1'b1, 1'b0, 1'b0);
        waitResult(200);

        // Saturation on the 4-bit instance: about 33 edges must clamp at 15.
        s_start = cyc;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("sat_en_b", en_s_b, 1'b1);
        n = 0;
        while (valid_s !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("sat_valid", valid_s, 1'b1);
        checkOutput("sat_latency", cyc - s_start, LAT);
        checkOutput("sat_cnt_a", cnt_s_a, 15);
        checkOutput("sat_cnt_b", cnt_s_b, 0);
        checkOutput("sat_resp_tie", {resp_s, tie_s}, 2'b10);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/puf_ro_counter.md
PUF_RO_COUNTER -- requirements
Module: puf_ro_counter

Interface
REQ-001 SHALL provide parameter CNT_W, default 16: width of each edge counter.
REQ-002 SHALL provide parameter WIN_CYCLES, default 1024: measurement window length in i_clk cycles, range 1..2^20.
REQ-003 SHALL provide parameter SETTLE_CYCLES, default 8: cycles allowed for RO start-up before counting, range 1..255.
REQ-004 Ports, in order:
  i_clk  input  1  system clock; one clock domain, all state rising-edge.
  i_rst_n  input  1  reset, asynchronous, active-low.
  i_start  input  1  single-cycle request for one measurement.
  o_en_a  output  1  enable to RO instance A.
  o_en_b  output  1  enable to RO instance B.
  i_ro_a  input  1  RO A output; asynchronous to i_clk.
  i_ro_b  input  1  RO B output; asynchronous to i_clk.
  o_busy  output  1  high from accepted start until o_valid.
  o_valid  output  1  one-cycle pulse when a result is ready.
  o_resp  output  1  PUF response bit.
  o_tie  output  1  counts equal.
  o_cnt_a  output  CNT_W  final edge count of A.
  o_cnt_b  output  CNT_W  final edge count of B.

Function
REQ-005 SHALL pass each of i_ro_a and i_ro_b through a 2-flop synchronizer, then a third history flop.
REQ-006 SHALL detect a rising edge when the synchronized value is 1 and the history value is 0.
REQ-007 SHALL implement FSM states IDLE, SETTLE, MEASURE, DONE.
REQ-008 IDLE: when i_start=1, SHALL go to SETTLE on the next edge; otherwise remain in IDLE.
REQ-009 On the IDLE->SETTLE transition, SHALL clear both counters and the cycle counter.
REQ-010 o_en_a and o_en_b SHALL be 1 in SETTLE and MEASURE, and 0 in IDLE and DONE.
REQ-011 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to MEASURE; edges seen in SETTLE SHALL NOT be counted.
REQ-012 MEASURE SHALL last exactly WIN_CYCLES cycles, then go to DONE.
REQ-013 In MEASURE, each detected rising edge SHALL increment its counter by 1.
REQ-014 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-015 DONE SHALL last one cycle, then go to IDLE.
REQ-016 In DONE, SHALL assert o_valid=1 and register the following, all held until the next DONE:
  o_cnt_a and o_cnt_b = counter values;
  o_resp = 1 when cnt_a > cnt_b, else 0;
  o_tie = 1 when cnt_a == cnt_b.
REQ-017 o_busy SHALL be 1 in SETTLE, MEASURE and DONE; 0 in IDLE.
REQ-018 i_start SHALL be ignored when not in IDLE, including in the DONE cycle.
REQ-019 Start-to-o_valid latency SHALL be SETTLE_CYCLES+WIN_CYCLES+1 cycles.
REQ-020 Edges during the MEASURE->DONE transition cycle SHALL NOT be counted.
REQ-021 Correct counting requires RO frequency < f(i_clk)/2; faster ROs SHALL alias without error indication.

Reset
REQ-022 While i_rst_n=0, the following SHALL be held immediately, independent of i_clk:
  FSM = IDLE;
  all counters, synchronizer and history flops = 0;
  o_en_a, o_en_b, o_busy, o_valid, o_resp, o_tie = 0;
  o_cnt_a, o_cnt_b = 0.
REQ-023 Reset asserted mid-SETTLE or mid-MEASURE SHALL abort the measurement, with no o_valid pulse, and drop the RO enables.
REQ-024 After deassertion, the first i_start SHALL be accepted on the first i_clk edge.

Verification
REQ-025 Basic measurement. Setup: i_clk 10 ns, WIN_CYCLES=100, SETTLE_CYCLES=8, ro_a period 40 ns, ro_b period 50 ns, both started while o_en high.
  Stimulus: one i_start pulse.
  Response: o_valid 109 cycles later; o_cnt_a 25±1, o_cnt_b 20±1, o_resp=1, o_tie=0.
REQ-026 Tie. Stimulus: ro_a = ro_b = 40 ns, in phase.
  Response: o_cnt_a == o_cnt_b, o_tie=1, o_resp=0.
REQ-027 Saturation. Setup: CNT_W=4, WIN_CYCLES=100, ro_a period 30 ns.
  Response: o_cnt_a=15, no wrap.
REQ-028 Start while busy. Stimulus: i_start pulses in SETTLE, in MEASURE, and in the DONE cycle.
  Response: exactly one o_valid; FSM returns to IDLE.
REQ-029 Reset mid-MEASURE. Stimulus: i_rst_n low at cycle 50 of MEASURE.
  Response: o_en_a=o_en_b=0 and o_busy=0 immediately; no o_valid; a new i_start yields a full-latency result.
REQ-030 Held outputs. Stimulus: two back-to-back measurements with swapped RO periods.
  Response: o_resp=1, then 0; o_cnt values hold between o_valid pulses.
